// File: rtl/modbus_rtu_pkg.sv
// Shared constants for the Modbus RTU receive path.
// CHAR_BITS is one RTU character (start + 8 data + parity/stop + stop).
// t15_cnt / t35_cnt turn a clock/baud pair into the 1.5 and 3.5
// character silence lengths, in clock cycles.
package modbus_rtu_pkg;

  localparam int CHAR_BITS = 11;

  function automatic int bit_cnt(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // 1.5 chars = 33/2 bits; multiply before halving to keep the half bit.
  function automatic int t15_cnt(input int clk_freq, input int baud_rate);
    return bit_cnt(clk_freq, baud_rate) * (3 * CHAR_BITS) / 2;
  endfunction

  // 3.5 chars = 77/2 bits.
  function automatic int t35_cnt(input int clk_freq, input int baud_rate);
    return bit_cnt(clk_freq, baud_rate) * (7 * CHAR_BITS) / 2;
  endfunction

endpackage

// File: rtl/modbus_rtu_gap_buffer_gap_timer.sv
// gap_timer: one-shot silence detector.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   rx_done    - end-of-byte pulse; arms the timer and restarts the count
//   rx_state   - byte in progress; disarms the timer
//   gap_pulse  - registered one-cycle pulse GAP_CNT cycles after rx_done
// GAP_CNT must be at least 2.
module gap_timer #(
  parameter int GAP_CNT = 7161
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_done,
  input  logic rx_state,
  output logic gap_pulse
);

  localparam int CW = (GAP_CNT > 2) ? $clog2(GAP_CNT) : 1;

  logic          armed;
  logic [CW-1:0] cnt;

  // rx_done high in cycle 0 puts cnt=0 in cycle 1, so cnt is k-1 in cycle k.
  // The increment that would land on GAP_CNT-1 happens at the end of cycle
  // GAP_CNT-1, which is exactly when the registered pulse must be loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      cnt       <= '0;
      gap_pulse <= 1'b0;
    end else begin
      gap_pulse <= 1'b0;
      if (rx_done) begin
        armed <= 1'b1;
        cnt   <= '0;
      end else if (rx_state) begin
        armed <= 1'b0;
        cnt   <= '0;
      end else if (armed) begin
        if (cnt == CW'(GAP_CNT - 2)) begin
          gap_pulse <= 1'b1;
          armed     <= 1'b0;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modbus_rtu_gap_buffer.sv
// modbus_rtu_gap_buffer: RTU receive gap detection plus the dual-port word
// RAM between the function handler (port A) and response builder (port B).
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   rx_done, rx_state           - byte receiver handshake
//   rx_new_frame                - pulse after 3.5 char times of silence
//   rx_drop_frame               - pulse after 1.5 char times of silence
//   ena/wea/addra/dia -> doa    - RAM port A (read-first, 1-cycle read)
//   enb/web/addrb/dib -> dob    - RAM port B (read-first, 1-cycle read)
module modbus_rtu_gap_buffer
  import modbus_rtu_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int A_WIDTH   = 4,
  parameter int D_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_done,
  input  logic               rx_state,
  output logic               rx_new_frame,
  output logic               rx_drop_frame,
  input  logic               ena,
  input  logic               wea,
  input  logic [A_WIDTH-1:0] addra,
  input  logic [D_WIDTH-1:0] dia,
  output logic [D_WIDTH-1:0] doa,
  input  logic               enb,
  input  logic               web,
  input  logic [A_WIDTH-1:0] addrb,
  input  logic [D_WIDTH-1:0] dib,
  output logic [D_WIDTH-1:0] dob
);

  localparam int T15 = t15_cnt(CLK_FREQ, BAUD_RATE);
  localparam int T35 = t35_cnt(CLK_FREQ, BAUD_RATE);

  gap_timer #(.GAP_CNT(T15)) u_t15 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_state  (rx_state),
    .gap_pulse (rx_drop_frame)
  );

  gap_timer #(.GAP_CNT(T35)) u_t35 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_state  (rx_state),
    .gap_pulse (rx_new_frame)
  );

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  // Single write process so a same-address collision is deterministic:
  // port A's assignment comes last and therefore wins.
  always_ff @(posedge clk) begin
    if (enb && web) mem[addrb] <= dib;
    if (ena && wea) mem[addra] <= dia;
  end

  // Read registers sample the pre-write array, giving read-first behaviour
  // on both the own-port and cross-port same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   doa <= '0;
    else if (ena) doa <= mem[addra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dob <= '0;
    else if (enb) dob <= mem[addrb];
  end

endmodule

// File: tb/tb_modbus_rtu_gap_buffer.sv
module tb_modbus_rtu_gap_buffer;

  localparam int T15 = 7161;
  localparam int T35 = 16709;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done, rx_state;
  logic        rx_new_frame, rx_drop_frame;
  logic        ena, wea, enb, web;
  logic [3:0]  addra, addrb;
  logic [15:0] dia, dib, doa, dob;

  modbus_rtu_gap_buffer dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_state(rx_state),
    .rx_new_frame(rx_new_frame), .rx_drop_frame(rx_drop_frame),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Gap bookkeeping: cyc is the current cycle index relative to the
  // scenario's cycle 0; inputs set while cyc==k are sampled at the end of k.
  int cyc, drop_n, new_n, drop_at, new_at;

  task automatic clr();
    cyc = 0; drop_n = 0; new_n = 0; drop_at = -1; new_at = -1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rx_drop_frame === 1'b1) begin drop_n++; drop_at = cyc; end
    if (rx_new_frame === 1'b1)  begin new_n++;  new_at = cyc;  end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  typedef struct {
    logic ena, wea; logic [3:0] addra; logic [15:0] dia;
    logic enb, web; logic [3:0] addrb; logic [15:0] dib;
    logic ca; logic [15:0] ea; logic cb; logic [15:0] eb;
  } vec_t;

  function automatic vec_t mk(input logic a_en, a_we, input logic [3:0] a_ad, input logic [15:0] a_d,
                              input logic b_en, b_we, input logic [3:0] b_ad, input logic [15:0] b_d,
                              input logic ca, input logic [15:0] ea, input logic cb, input logic [15:0] eb);
    vec_t v;
    v.ena = a_en; v.wea = a_we; v.addra = a_ad; v.dia = a_d;
    v.enb = b_en; v.web = b_we; v.addrb = b_ad; v.dib = b_d;
    v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
    return v;
  endfunction

  vec_t vt [12];

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_state = 1'b0;
    ena = 0; wea = 0; enb = 0; web = 0; addra = 0; addrb = 0; dia = 0; dib = 0;

    // expected do = word read by this vector's address (1-cycle latency)
    vt[0]  = mk(1,1,4'd3, 16'h1234, 0,0,4'd0, 16'h0,    0,16'h0,    1,16'h0000);
    vt[1]  = mk(1,1,4'd15,16'hABCD, 1,0,4'd3, 16'h0,    0,16'h0,    1,16'h1234);
    vt[2]  = mk(1,0,4'd3, 16'h0,    1,0,4'd15,16'h0,    1,16'h1234, 1,16'hABCD);
    vt[3]  = mk(1,1,4'd5, 16'h0055, 0,0,4'd0, 16'h0,    0,16'h0,    1,16'hABCD);
    vt[4]  = mk(1,1,4'd5, 16'h1111, 1,1,4'd5, 16'h2222, 1,16'h0055, 1,16'h0055);
    vt[5]  = mk(1,0,4'd5, 16'h0,    1,0,4'd5, 16'h0,    1,16'h1111, 1,16'h1111);
    vt[6]  = mk(1,1,4'd7, 16'h7777, 1,0,4'd3, 16'h0,    0,16'h0,    1,16'h1234);
    vt[7]  = mk(1,1,4'd7, 16'h8888, 1,0,4'd7, 16'h0,    1,16'h7777, 1,16'h7777);
    vt[8]  = mk(0,0,4'd0, 16'h0,    1,0,4'd7, 16'h0,    1,16'h7777, 1,16'h8888);
    vt[9]  = mk(1,0,4'd3, 16'h0,    1,1,4'd3, 16'hBEEF, 1,16'h1234, 1,16'h1234);
    vt[10] = mk(0,1,4'd3, 16'h0000, 1,0,4'd3, 16'h0,    1,16'h1234, 1,16'hBEEF);
    vt[11] = mk(1,0,4'd3, 16'h0,    0,0,4'd0, 16'h0,    1,16'hBEEF, 1,16'hBEEF);

    repeat (3) @(negedge clk);
    chk("reset new_frame", rx_new_frame, 0);
    chk("reset drop_frame", rx_drop_frame, 0);
    chk("reset doa", doa, 0);
    chk("reset dob", dob, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- RAM table ----
    for (int i = 0; i < 12; i++) begin
      ena = vt[i].ena; wea = vt[i].wea; addra = vt[i].addra; dia = vt[i].dia;
      enb = vt[i].enb; web = vt[i].web; addrb = vt[i].addrb; dib = vt[i].dib;
      @(posedge clk);
      @(negedge clk);
      if (vt[i].ca) chk($sformatf("ram v%0d doa", i), doa, vt[i].ea);
      if (vt[i].cb) chk($sformatf("ram v%0d dob", i), dob, vt[i].eb);
    end
    ena = 0; wea = 0; enb = 0; web = 0;

    // ---- single byte end ----
    clr(); rx_done = 1'b1; step(); rx_done = 1'b0;
    run_to(T35 + 500);
    chk("single drop count", drop_n, 1);
    chk("single drop cycle", drop_at, T15);
    chk("single new count", new_n, 1);
    chk("single new cycle", new_at, T35);

    // ---- back-to-back bytes ----
    clr(); rx_done = 1'b1; step(); rx_done = 1'b0;
    run_to(3000); rx_state = 1'b1;
    run_to(4000); rx_done = 1'b1; rx_state = 1'b0; step(); rx_done = 1'b0;
    run_to(4000 + T35 + 100);
    chk("b2b drop count", drop_n, 1);
    chk("b2b drop cycle", drop_at, 4000 + T15);
    chk("b2b new count", new_n, 1);
    chk("b2b new cycle", new_at, 4000 + T35);

    // ---- intra-frame violation ----
    clr(); rx_done = 1'b1; step(); rx_done = 1'b0;
    run_to(10000); rx_state = 1'b1;
    run_to(T35 + 100);
    chk("viol drop count", drop_n, 1);
    chk("viol drop cycle", drop_at, T15);
    chk("viol new count", new_n, 0);
    rx_state = 1'b0;

    // ---- reset mid-gap, then idle ----
    clr(); rx_done = 1'b1; step(); rx_done = 1'b0;
    run_to(5000);
    rst_n = 1'b0;
    #1;
    chk("rst drop low", rx_drop_frame, 0);
    chk("rst new low", rx_new_frame, 0);
    chk("rst doa", doa, 0);
    chk("rst dob", dob, 0);
    repeat (3) step();
    rst_n = 1'b1;
    run_to(5000 + T35 + 100);
    chk("rst drop count", drop_n, 0);
    chk("rst new count", new_n, 0);
    chk("idle drop low", rx_drop_frame, 0);
    chk("idle new low", rx_new_frame, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
